// File: rtl/timer_dev.sv
// timer_dev: programmable down-counting timer with CTRL/PRESET/COUNT registers,
// one-shot and auto-reload modes, and a maskable level interrupt.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Architectural state
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        pending;

  // Bus decode
  logic        wr_ctrl;
  logic        wr_preset;

  // FSM action strobes
  logic        do_load;
  logic        do_dec;
  logic        do_expire;
  logic        do_clr_en;
  logic        do_ack;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  // State register.
  // NOTE: reset is synchronous here, so it lives inside the clocked branch and
  // is only seen on a rising edge; sequential state always uses <= so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision from the current state, EN and COUNT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = en ? LOAD : IDLE;
      LOAD: state_nxt = CNT;
      CNT: begin
        if (!en)                state_nxt = IDLE;
        else if (count > 32'd1) state_nxt = CNT;
        else                    state_nxt = INT;
      end
      INT:  state_nxt = IDLE;
    endcase
  end

  // Per-state action strobes consumed by the register processes below.
  // NOTE: every output of a combinational block is given a default first so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_load   = 1'b0;
    do_dec    = 1'b0;
    do_expire = 1'b0;
    do_clr_en = 1'b0;
    do_ack    = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: do_load = 1'b1;
      CNT: begin
        if (en) begin
          if (count > 32'd1) do_dec    = 1'b1;
          else               do_expire = 1'b1;
        end
      end
      INT: begin
        // Auto-reload acknowledges in hardware; every other mode is one-shot.
        if (mode == MODE_RELOAD) do_ack    = 1'b1;
        else                     do_clr_en = 1'b1;
      end
    endcase
  end

  // CTRL: bus write takes priority over the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en   <= 1'b0;
      mode <= 2'b00;
      im   <= 1'b0;
    end else if (wr_ctrl) begin
      en   <= wdata[0];
      mode <= wdata[2:1];
      im   <= wdata[3];
    end else if (do_clr_en) begin
      en   <= 1'b0;
    end
  end

  // PRESET: plain read/write reload value, only sampled by the LOAD state.
  always_ff @(posedge clk) begin
    if (!reset)         preset <= 32'd0;
    else if (wr_preset) preset <= wdata;
  end

  // COUNT: reload, decrement, or clamp to zero on expiry; never bus-written.
  always_ff @(posedge clk) begin
    if (!reset)         count <= 32'd0;
    else if (do_load)   count <= preset;
    else if (do_dec)    count <= count - 32'd1;
    else if (do_expire) count <= 32'd0;
  end

  // pending: a CTRL/PRESET write clears it and beats a simultaneous expiry.
  always_ff @(posedge clk) begin
    if (!reset)                      pending <= 1'b0;
    else if (wr_ctrl || wr_preset)   pending <= 1'b0;
    else if (do_expire)              pending <= 1'b1;
    else if (do_ack)                 pending <= 1'b0;
  end

  // Read mux; CTRL upper bits and the reserved word read as zero.
  always_comb begin
    rdata = 32'd0;
    unique case (addr)
      ADDR_CTRL:   rdata = {28'd0, im, mode, en};
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = im & pending;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: table-driven register checks, directed multi-cycle sequences
// and randomized traffic compared against a behavioural model of the timer.
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_dev dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phases of the timer life cycle as described by the rules.
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;

  bit [3:0]  m_ctrl;
  bit [31:0] m_preset;
  bit [31:0] m_count;
  bit        m_pending;
  int        m_phase;

  task automatic model_edge(input bit r, input bit w, input bit [1:0] a,
                            input bit [31:0] d);
    if (!r) begin
      m_ctrl = 0; m_preset = 0; m_count = 0; m_pending = 0;
      m_phase = PH_IDLE;
      return;
    end
    // Timer rules first, using the values visible before this edge.
    case (m_phase)
      PH_IDLE: if (m_ctrl[0]) m_phase = PH_LOAD;
      PH_LOAD: begin m_count = m_preset; m_phase = PH_CNT; end
      PH_CNT: begin
        if (!m_ctrl[0]) m_phase = PH_IDLE;
        else if (m_count > 1) m_count = m_count - 1;
        else begin m_count = 0; m_pending = 1; m_phase = PH_INT; end
      end
      default: begin
        if (m_ctrl[2:1] == 2'b01) m_pending = 0;
        else                      m_ctrl[0] = 0;
        m_phase = PH_IDLE;
      end
    endcase
    // Bus writes override whatever the timer did this edge.
    if (w && a == 2'd0) m_ctrl = d[3:0];
    if (w && a == 2'd1) m_preset = d;
    if (w && (a == 2'd0 || a == 2'd1)) m_pending = 0;
  endtask

  function automatic bit [31:0] model_read(input int a);
    case (a)
      0:       return {28'd0, m_ctrl};
      1:       return m_preset;
      2:       return m_count;
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  logic [31:0] rd_snap [4];
  logic        irq_snap;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sweeps all four addresses while clk is low, comparing against the model.
  task automatic check_model();
    irq_snap = irq;
    check("model_irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_pending});
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0];
      #1;
      rd_snap[a] = rdata;
      check($sformatf("model_rd%0d", a), rdata, model_read(a));
    end
    addr = 2'd0;
  endtask

  // One clock: drive inputs, take the edge, advance model, check at negedge.
  task automatic cycle(input bit r, input bit w, input bit [1:0] a,
                       input bit [31:0] d);
    reset = r; we = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(r, w, a, d);
    @(negedge clk);
    reset = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  // ---------------- register access table ----------------
  typedef struct {
    bit          rst;
    bit          wr;
    bit [1:0]    a;
    bit [31:0]   d;
    int          rd_addr;
    bit [31:0]   exp_rd;
    bit          exp_irq;
  } vec_t;

  vec_t vecs [9];

  initial begin
    reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = 32'd0;
    m_ctrl = 0; m_preset = 0; m_count = 0; m_pending = 0; m_phase = PH_IDLE;

    vecs[0] = '{1'b0, 1'b0, 2'd0, 32'h0,        0, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 1'b1, 2'd1, 32'h12345678, 1, 32'h12345678, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 2'd2, 32'h0000DEAD, 2, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 1'b1, 2'd3, 32'h0000FFFF, 3, 32'h0,        1'b0};
    vecs[4] = '{1'b1, 1'b1, 2'd0, 32'hFFFFFFF0, 0, 32'h0,        1'b0};
    vecs[5] = '{1'b1, 1'b1, 2'd0, 32'h0000000E, 0, 32'hE,        1'b0};
    vecs[6] = '{1'b1, 1'b0, 2'd0, 32'h0,        1, 32'h12345678, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'd0, 32'h0000000F, 0, 32'h0,        1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'd0, 32'h0,        1, 32'h0,        1'b0};

    @(negedge clk);

    // Table: register access, ignored writes, reset priority.
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].rst, vecs[i].wr, vecs[i].a, vecs[i].d);
      check($sformatf("vec%0d_rd", i), rd_snap[vecs[i].rd_addr], vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'd0, irq_snap}, {31'd0, vecs[i].exp_irq});
    end

    // One-shot, PRESET=3: COUNT 3,2,1,0 after edges 2..5, irq at edge 5.
    begin
      bit [31:0] exp_cnt [6];
      bit        exp_irq [6];
      exp_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      cycle(1'b1, 1'b1, 2'd1, 32'd3);
      cycle(1'b1, 1'b1, 2'd0, 32'h9);
      for (int k = 1; k <= 5; k++) begin
        idle(1);
        check($sformatf("oneshot_cnt_e%0d", k), rd_snap[2], exp_cnt[k]);
        check($sformatf("oneshot_irq_e%0d", k), {31'd0, irq_snap}, {31'd0, exp_irq[k]});
      end
      idle(1);
      check("oneshot_ctrl_after", rd_snap[0], 32'h8);
      idle(4);
      check("oneshot_irq_held", {31'd0, irq_snap}, 32'd1);
      cycle(1'b1, 1'b1, 2'd0, 32'h8);
      check("oneshot_irq_cleared", {31'd0, irq_snap}, 32'd0);
    end

    // Auto-reload, PRESET=2: 1-cycle irq pulse every 5 cycles from edge 4.
    do_reset();
    cycle(1'b1, 1'b1, 2'd1, 32'd2);
    cycle(1'b1, 1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 15; k++) begin
      idle(1);
      check($sformatf("reload_irq_e%0d", k), {31'd0, irq_snap},
            {31'd0, (k >= 4 && (k - 4) % 5 == 0)});
    end
    check("reload_ctrl_en", rd_snap[0], 32'hB);

    // Masked one-shot: no irq, EN clears, later CTRL=0x8 keeps irq low.
    do_reset();
    cycle(1'b1, 1'b1, 2'd1, 32'd2);
    cycle(1'b1, 1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      check($sformatf("masked_irq_e%0d", k), {31'd0, irq_snap}, 32'd0);
    end
    check("masked_count", rd_snap[2], 32'd0);
    check("masked_ctrl", rd_snap[0], 32'd0);
    cycle(1'b1, 1'b1, 2'd0, 32'h8);
    check("masked_unmask_irq", {31'd0, irq_snap}, 32'd0);
    idle(2);
    check("masked_unmask_irq2", {31'd0, irq_snap}, 32'd0);

    // Pause at 6 and reload on re-enable.
    do_reset();
    cycle(1'b1, 1'b1, 2'd1, 32'd10);
    cycle(1'b1, 1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 40 && rd_snap[2] != 32'd7; i++) idle(1);
    check("pause_reach7", rd_snap[2], 32'd7);
    cycle(1'b1, 1'b1, 2'd0, 32'h0);
    check("pause_at6", rd_snap[2], 32'd6);
    idle(3);
    check("pause_hold6", rd_snap[2], 32'd6);
    cycle(1'b1, 1'b1, 2'd0, 32'h1);
    idle(1);
    check("pause_edge1", rd_snap[2], 32'd6);
    idle(1);
    check("pause_reload10", rd_snap[2], 32'd10);

    // Reset mid-count with a simultaneous write.
    do_reset();
    cycle(1'b1, 1'b1, 2'd1, 32'd100);
    cycle(1'b1, 1'b1, 2'd0, 32'h9);
    idle(10);
    cycle(1'b0, 1'b1, 2'd0, 32'hF);
    for (int a = 0; a < 4; a++)
      check($sformatf("midreset_rd%0d", a), rd_snap[a], 32'd0);
    check("midreset_irq", {31'd0, irq_snap}, 32'd0);
    idle(4);
    check("midreset_irq_later", {31'd0, irq_snap}, 32'd0);
    check("midreset_count_later", rd_snap[2], 32'd0);

    // PRESET=0 expires at edge 3, then bus-vs-hardware collisions.
    do_reset();
    cycle(1'b1, 1'b1, 2'd0, 32'h9);
    idle(2);
    check("p0_irq_e2", {31'd0, irq_snap}, 32'd0);
    idle(1);
    check("p0_irq_e3", {31'd0, irq_snap}, 32'd1);
    cycle(1'b1, 1'b1, 2'd0, 32'h9);      // CTRL write during INT: bus wins
    check("int_write_ctrl", rd_snap[0], 32'h9);
    check("int_write_irq", {31'd0, irq_snap}, 32'd0);
    idle(2);
    cycle(1'b1, 1'b1, 2'd1, 32'd5);      // PRESET write at CNT->INT edge
    check("expire_clear_irq", {31'd0, irq_snap}, 32'd0);
    check("expire_clear_cnt", rd_snap[2], 32'd0);
    idle(1);
    check("expire_clear_ctrl", rd_snap[0], 32'h8);

    // CTRL all-ones reads back only the implemented bits.
    do_reset();
    cycle(1'b1, 1'b1, 2'd0, 32'hFFFFFFFF);
    check("ctrl_all_ones", rd_snap[0], 32'hF);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit        r;
      bit [1:0]  a;
      bit [31:0] d;
      r = ($urandom_range(199) != 0);
      a = 2'($urandom_range(3));
      if (a == 2'd1) d = $urandom_range(6);
      else           d = $urandom;
      if ($urandom_range(9) < 7) cycle(r, 1'b0, 2'd0, 32'd0);
      else                       cycle(r, 1'b1, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/timer_dev.md
TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 Parameters: none; all register layouts and encodings are fixed by this document.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk.
REQ-004 addr  input  2  word offset within the device (byte address bits [3:2]): 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved.
REQ-005 we  input  1  write enable for the addressed register; write is committed on the rising edge.
REQ-006 wdata  input  32  write data from the CPU bridge.
REQ-007 rdata  output  32  read data for the addressed register; combinational from addr and current register state.
REQ-008 irq  output  1  interrupt request to the CPU; level, active-high.

Function
REQ-009 CTRL fields: [0] EN, [2:1] MODE, [3] IM (interrupt mask, 1 = enabled); CTRL bits [31:4] SHALL be stored as 0 and read as 0.
REQ-010 PRESET: 32-bit read/write reload value; COUNT: 32-bit read-only, and writes to addr 2 SHALL be ignored.
REQ-011 Reads from addr 3 SHALL return 0, and writes to addr 3 SHALL be ignored.
REQ-012 FSM states: IDLE, LOAD, CNT, INT.
REQ-013 IDLE: EN=1 -> LOAD; otherwise stay in IDLE, and COUNT holds.
REQ-014 LOAD: COUNT <= PRESET; -> CNT.
REQ-015 CNT, EN=0: -> IDLE with COUNT held (pause); a later EN=1 passes through LOAD, so COUNT reloads.
REQ-016 CNT, EN=1, COUNT>1: COUNT <= COUNT-1; stay in CNT.
REQ-017 CNT, EN=1, COUNT<=1: COUNT <= 0; pending <= 1; -> INT.
REQ-018 INT, MODE=00: hardware clears EN; -> IDLE; pending stays set.
REQ-019 INT, MODE=01: EN unchanged; pending <= 0; -> IDLE, so the timer auto-reloads while EN=1.
REQ-020 MODE=10 and MODE=11 SHALL behave as MODE=00.
REQ-021 irq = IM & pending, combinational from registered state with no additional latency.
REQ-022 pending SHALL be cleared by any committed write to CTRL or PRESET.
REQ-023 A write to CTRL in the same cycle as the INT-state EN clear: the bus write wins.
REQ-024 A write that clears pending in the same cycle as the CNT->INT transition: the clear wins, so pending = 0.
REQ-025 A write to PRESET while in CNT SHALL NOT alter COUNT; the new value takes effect at the next LOAD.
REQ-026 Latency: a CTRL write with EN=1 at edge 0 puts the FSM in LOAD after edge 1 and loads COUNT=PRESET at edge 2.
REQ-027 Expiry timing: for PRESET = P >= 2, pending rises at edge P+2; for P = 0 or P = 1, pending rises at edge 3.
REQ-028 COUNT arithmetic is unsigned 32-bit, and COUNT SHALL never wrap below 0.

Reset
REQ-029 reset=0 at a rising edge SHALL force CTRL=0, PRESET=0, COUNT=0, pending=0, state=IDLE, irq=0.
REQ-030 A reset asserted mid-count SHALL abort the count with no irq; reset overrides any simultaneous bus write.
REQ-031 rdata SHALL reflect the reset values during and immediately after reset.

Verification
REQ-032 One-shot: PRESET=3, then CTRL=0x9 (EN, MODE 00, IM).
- Required: COUNT reads 3, 2, 1, 0 on successive cycles and irq rises 5 cycles after the CTRL write.
- Required after expiry: CTRL reads 0x8 and irq stays high until the next CTRL write.
REQ-033 Auto-reload: PRESET=2, CTRL=0xB.
- Required: irq is a 1-cycle pulse repeating every 5 cycles (INT, IDLE, LOAD, then 2 CNT cycles), and EN stays 1.
REQ-034 Masked: PRESET=2, CTRL=0x1.
- Required: irq stays 0 throughout, and COUNT reaches 0 with EN cleared.
- Then write CTRL=0x8: irq stays 0, because the write clears pending.
REQ-035 Pause and reload: PRESET=10, start the count, clear EN when COUNT=6.
- Required: COUNT holds at 6.
- Then set EN again: COUNT reloads to 10 two cycles later.
REQ-036 Reset and boundaries: assert reset=0 mid-count with PRESET=100.
- Required: all registers read 0 next cycle and irq stays 0.
- Also check: PRESET=0 expires at edge 3; a COUNT write is ignored; addr 3 reads 0; CTRL write 0xFFFFFFFF reads back 0xF.
